// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter.
// No logic; imported by the arbiter, its sub-module and the bench.
package dmem_pkg;
  typedef logic master_id_t;

  localparam master_id_t MST_CORE = 1'b0;
  localparam master_id_t MST_DBG  = 1'b1;

  localparam logic [31:0] DMEM_ERR_RDATA = 32'hBADACCE5;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Two-master req/gnt/rvalid bus; per-master fields are packed [1:0] arrays indexed by master id.
// The response data bus is shared and qualified per master by rvalid.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [1:0]                 req;
  logic [1:0]                 gnt;
  logic [1:0]                 we;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][BE_WIDTH-1:0]   be;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic [1:0]                 rvalid;
  logic [1:0]                 err;
  logic [DATA_WIDTH-1:0]      rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a debug lock; grant is combinational, pointer/lock update on grant.
// Reset masks all grants so nothing reaches the RAM while rst is high.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt,
  output master_id_t gnt_id
);
  master_id_t rr_ptr;
  logic       lock_q;

  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      gnt = 2'b00;
    end else if (lock_q) begin
      gnt[MST_DBG] = req[MST_DBG];
    end else if (&req) begin
      gnt[rr_ptr] = 1'b1;
    end else begin
      gnt = req;
    end
    gnt_id = gnt[MST_DBG] ? MST_DBG : MST_CORE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= MST_CORE;
      lock_q <= 1'b0;
    end else begin
      if (|gnt) rr_ptr <= ~gnt_id;
      // Lock also drops as soon as the debug master stops requesting.
      if (gnt[MST_DBG])       lock_q <= lock;
      else if (!req[MST_DBG]) lock_q <= 1'b0;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two masters onto the single-port data RAM; response returns 1 cycle after grant, no backpressure.
// Optional range/alignment check enabled by DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_i,
  dmem_arbiter_if.slave         bus,
  input  logic                  lock_i,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [BE_WIDTH-1:0]   ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);
  logic [1:0]            gnt;
  master_id_t            gnt_id;
  logic                  oor;
  logic                  resp_valid_q;
  master_id_t            resp_id_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] resp_data;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst_i),
    .req    (bus.req),
    .lock   (lock_i),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bus.gnt = gnt;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign oor = (|gnt) && ((32'(bus.addr[gnt_id]) >= 32'(RAM_SIZE)) ||
                          (bus.addr[gnt_id][1:0] != 2'b00));
`else
  assign oor = 1'b0;
`endif

  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if ((|gnt) && !oor) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = bus.addr[gnt_id];
      ram_we_o    = bus.we[gnt_id];
      ram_be_o    = bus.be[gnt_id];
      ram_wdata_o = bus.wdata[gnt_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= MST_CORE;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      resp_valid_q <= |gnt;
      resp_id_q    <= gnt_id;
      resp_err_q   <= oor;
      if (resp_valid_q) rdata_q <= resp_data;
    end
  end

  assign resp_data = resp_err_q ? DATA_WIDTH'(DMEM_ERR_RDATA) : ram_rdata_i;

  // A response landing in a reset cycle is dropped rather than delivered.
  always_comb begin
    bus.rvalid = 2'b00;
    bus.err    = 2'b00;
    bus.rdata  = rdata_q;
    if (resp_valid_q && !rst_i) begin
      bus.rvalid[resp_id_q] = 1'b1;
      bus.err[resp_id_q]    = resp_err_q;
      bus.rdata             = resp_data;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural 1-cycle RAM, per-cycle scoreboard of expected responses.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 15;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]  rv;
    logic [1:0]  er;
    logic        cd;
    logic [31:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          lock;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [31:0]   mem [0:8191];

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(.RAM_SIZE(32768), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_i       (rst),
    .bus         (bus),
    .lock_i      (lock),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr[AW-1:2]];
      if (ram_we)
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[AW-1:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: check grant/enable now, retire last cycle's expected response, queue this one.
  task automatic cyc(input logic [1:0] eg, input logic oor, input logic cd, input logic [31:0] ed);
    exp_t e;
    #2;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("ram_en", 32'(ram_en), 32'((|eg) & ~oor));
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (rst) begin
        e.rv = 2'b00;
        e.er = 2'b00;
        e.cd = 1'b0;
      end
      chk("rvalid", 32'(bus.rvalid), 32'(e.rv));
      chk("err", 32'(bus.err), 32'(e.er));
      if (e.cd) chk("rdata", bus.rdata, e.d);
    end
    e.rv = eg;
    e.er = oor ? eg : 2'b00;
    e.cd = cd;
    e.d  = ed;
    sbq.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.req     = req;
    bus.addr[0] = a0;
    bus.addr[1] = a1;
    bus.we      = 2'b00;
    bus.be      = {4'hF, 4'hF};
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[16'h100 >> 2] = 32'hDEADBEEF;
    mem[16'h200 >> 2] = 32'hFFFFFFFF;
    ram_rdata = '0;
    rst   = 1'b1;
    lock  = 1'b0;
    bus.wdata = '0;
    drive(2'b11, 15'h100, 15'h100);

    // Reset with both masters requesting: nothing granted.
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // First cycle out of reset prefers master 0.
    cyc(2'b01, 1'b0, 1'b1, 32'hDEADBEEF);
    drive(2'b01, 15'h100, 15'h0);
    cyc(2'b01, 1'b0, 1'b1, 32'hDEADBEEF);
    drive(2'b10, 15'h0, 15'h200);
    cyc(2'b10, 1'b0, 1'b1, 32'hFFFFFFFF);

    // Contention alternates.
    drive(2'b11, 15'h100, 15'h200);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 1'b0, 1'b1, 32'hDEADBEEF);
      cyc(2'b10, 1'b0, 1'b1, 32'hFFFFFFFF);
    end

    // Lock: m0 starves while lock_i is held, wins right after m1 releases.
    drive(2'b01, 15'h100, 15'h200);
    cyc(2'b01, 1'b0, 1'b1, 32'hDEADBEEF);
    drive(2'b11, 15'h100, 15'h200);
    lock = 1'b1;
    for (int i = 0; i < 3; i++) cyc(2'b10, 1'b0, 1'b1, 32'hFFFFFFFF);
    lock = 1'b0;
    cyc(2'b10, 1'b0, 1'b1, 32'hFFFFFFFF);
    cyc(2'b01, 1'b0, 1'b1, 32'hDEADBEEF);

    // Partial write then read back.
    drive(2'b01, 15'h200, 15'h0);
    bus.we[0]    = 1'b1;
    bus.be[0]    = 4'b0011;
    bus.wdata[0] = 32'h12345678;
    #1;
    chk("wr_we", 32'(ram_we), 32'h1);
    chk("wr_be", 32'(ram_be), 32'h3);
    chk("wr_addr", 32'(ram_addr), 32'h200);
    chk("wr_wdata", ram_wdata, 32'h12345678);
    cyc(2'b01, 1'b0, 1'b0, 32'h0);
    drive(2'b01, 15'h200, 15'h0);
    cyc(2'b01, 1'b0, 1'b1, 32'hFFFF5678);

    // Read then write to the same word back-to-back returns the old data.
    drive(2'b01, 15'h100, 15'h0);
    cyc(2'b01, 1'b0, 1'b1, 32'hDEADBEEF);
    bus.we[0]    = 1'b1;
    bus.wdata[0] = 32'h0;
    cyc(2'b01, 1'b0, 1'b0, 32'h0);
    drive(2'b01, 15'h100, 15'h0);
    cyc(2'b01, 1'b0, 1'b1, 32'h0);

    // Idle drives zeros to the RAM.
    drive(2'b00, 15'h100, 15'h200);
    #1;
    chk("idle_addr", 32'(ram_addr), 32'h0);
    cyc(2'b00, 1'b0, 1'b0, 32'h0);

    // Reset the cycle after a grant drops the response.
    mem[16'h100 >> 2] = 32'hCAFEF00D;
    drive(2'b01, 15'h100, 15'h0);
    cyc(2'b01, 1'b0, 1'b0, 32'h0);
    drive(2'b00, 15'h0, 15'h0);
    rst = 1'b1;
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    chk("post_rst_rdata", bus.rdata, 32'h0);

`ifdef DMEM_ARB_RANGE_CHECK_EN
    drive(2'b01, 15'h102, 15'h0);
    cyc(2'b01, 1'b1, 1'b1, 32'hBADACCE5);
`else
    drive(2'b01, 15'h102, 15'h0);
    #1;
    chk("unaligned_addr", 32'(ram_addr), 32'h102);
    cyc(2'b01, 1'b0, 1'b0, 32'h0);
`endif
    drive(2'b00, 15'h0, 15'h0);
    cyc(2'b00, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and protocol adapter directly upstream of the single-port data RAM wrapper.
- Master 0 is the core LSU data port; master 1 is the debug/bus-bridge port. Both use the req/gnt/rvalid protocol.
- Produces the RAM-side en/addr/we/be/wdata each cycle.
- Routes the RAM read data, which has a fixed 1-cycle latency, back to the granted master with rvalid.

Parameters:
- RAM_SIZE, 32768, data RAM size in bytes.
- ADDR_WIDTH, $clog2(RAM_SIZE), byte-address width seen by the masters and the RAM.
- DATA_WIDTH, 32, data width; BE_WIDTH = DATA_WIDTH/8.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_i  in  1  synchronous reset, active high.
- m_req_i  in  2  per-master request.
- m_gnt_o  out  2  per-master grant, combinational in the request cycle.
- m_addr_i  in  2 x ADDR_WIDTH  per-master byte address.
- m_we_i  in  2  per-master write enable.
- m_be_i  in  2 x BE_WIDTH  per-master byte enables.
- m_wdata_i  in  2 x DATA_WIDTH  per-master write data.
- m_rvalid_o  out  2  response valid, exactly 1 cycle after that master's grant.
- m_rdata_o  out  DATA_WIDTH  shared response data; qualified by m_rvalid_o.
- m_err_o  out  2  response error; only active with the optional feature.
- lock_i  in  1  master 1 holds the RAM across consecutive grants (debug atomic access).
- ram_en_o  out  1  RAM enable.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  BE_WIDTH  RAM byte enables.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en_o.

Behaviour:
- Clock and reset: one clock clk; reset rst_i is synchronous and active-high.
- Reset state:
  - rr_ptr = 0 (master 0 preferred); lock_q = 0; resp_valid_q = 0; resp_id_q = 0.
  - Outputs: m_rvalid_o = 0, m_err_o = 0, m_rdata_o = 0, ram_en_o = 0 the cycle after reset is sampled.
- Arbitration (combinational):
  - One request: that master is granted.
  - Both requesting: grant goes to the master indicated by rr_ptr.
  - After any grant, rr_ptr <= ~granted_id.
  - At most one gnt bit is high per cycle.
- Lock:
  - Set: lock_q <= 1 when master 1 is granted with lock_i = 1.
  - While lock_q = 1: master 0 is never granted and master 1 wins unconditionally.
  - Clear: lock_q <= 0 on a master-1 grant with lock_i = 0, or on any cycle with m_req_i[1] = 0.
- RAM drive:
  - ram_en_o = |m_gnt_o.
  - ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o mux the granted master's fields.
  - When idle, the RAM outputs are driven to 0.
- Response pipeline:
  - resp_valid_q <= |m_gnt_o; resp_id_q <= granted_id.
  - m_rvalid_o[resp_id_q] = resp_valid_q. Writes also get rvalid; rdata is don't-care for writes.
  - m_rdata_o = ram_rdata_i when resp_valid_q = 1, else hold the last value.
- Throughput: back-to-back grants every cycle, no bubbles; a read followed by a write to the same address returns the old data.
- Reset mid-operation: a pending response is dropped (no rvalid after reset); lock_q is cleared.
- Unsupported encoding: requests with m_be_i = 0 are still granted; the RAM sees we with be = 0, a no-op.

Optional Feature:
- Macro: DMEM_ARB_RANGE_CHECK_EN.
- When defined, a granted access is out of range if m_addr_i >= RAM_SIZE (only reachable when RAM_SIZE is not a power of two) or if m_addr_i[1:0] != 0.
  - The access is still granted, but ram_en_o = 0.
  - One cycle later: rvalid = 1, m_err_o[id] = 1, m_rdata_o = 32'hBADACCE5.
- When undefined: m_err_o is tied to 0, no check is done, and the address's low bits pass through.

Decomposition:
- Package dmem_pkg holds:
  - typedef master_id_t (1 bit);
  - constants MST_CORE = 0 and MST_DBG = 1;
  - constant DMEM_ERR_RDATA = 32'hBADACCE5.
- One natural sub-module: rr_arb2, the 2-way round-robin arbiter with lock (req, lock -> gnt, ptr update).

Test Plan:
- Reset then idle: assert rst_i for 2 cycles with both reqs high -> no gnt during reset; first cycle after reset master 0 is granted; all rvalid = 0 before that.
- Single read: RAM preloaded 0x100 = 32'hDEADBEEF; m0 reads 0x100 -> gnt[0] in the same cycle, rvalid[0] the next cycle, rdata = DEADBEEF.
- Contention: both request continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 and each rvalid matches the granted id one cycle later.
- Lock: m1 holds lock_i = 1 for 3 grants while m0 requests -> m0 starves for 3 cycles; m0 is granted the cycle after m1 drops lock_i.
- Write then read: m0 writes 0x200 with be = 4'b0011, data 32'h12345678, over 32'hFFFFFFFF, then reads it -> 32'hFFFF5678.
- Reset mid-flight and range check: rst_i asserted the cycle after a grant -> no rvalid. With DMEM_ARB_RANGE_CHECK_EN, a read of 0x102 -> ram_en_o = 0, err = 1, rdata = BADACCE5.
